// File: rtl/fifo_wptr_full_pkg.sv
//------------------------------------------------------------------------------
// Module  : fifo_wptr_full_pkg
// Brief   : Shared pointer-width helper and synchronizer depth for the
//           dual-clock FIFO pointer blocks. Depth is selected by FIFO_SYNC3_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_wptr_full_pkg;

    localparam int c_default_sync_stages = 2;

`ifdef FIFO_SYNC3_EN
    localparam int c_sync_stages = 3;
`else
    localparam int c_sync_stages = c_default_sync_stages;
`endif

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
//------------------------------------------------------------------------------
// Module  : fifo_wptr_full_if
// Brief   : Producer-side bundle of the FIFO write pointer/status block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_wptr_full_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   rptr_gray_async;
    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_level;
    logic                  overflow;

    modport master (
        output wr_en, rptr_gray_async,
        input  wr_fire, waddr, wptr_gray, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, rptr_gray_async,
        output wr_fire, waddr, wptr_gray, full, almost_full, wr_level, overflow
    );
endinterface

`default_nettype wire

// File: rtl/fifo_wptr_full_conv.sv
//------------------------------------------------------------------------------
// Module  : bin_to_gray_gen / gray_to_bin_gen
// Brief   : Combinational pointer converters; pointers are DATA_WIDTH+1 bits.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin_to_gray_gen #(
    parameter int DATA_WIDTH = 4
) (
    input  wire logic [DATA_WIDTH:0] bin,
    output logic      [DATA_WIDTH:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

module gray_to_bin_gen #(
    parameter int DATA_WIDTH = 4
) (
    input  wire logic [DATA_WIDTH:0] gray,
    output logic      [DATA_WIDTH:0] bin
);
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= DATA_WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[DATA_WIDTH:i];
    end
endmodule

`default_nettype wire

// File: rtl/fifo_wptr_full_sync.sv
//------------------------------------------------------------------------------
// Module  : gray_ptr_sync
// Brief   : N-stage flop synchronizer for a Gray pointer; no logic between
//           stages. Shared with the read-side pointer block.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_ptr_sync
    import fifo_wptr_full_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = c_default_sync_stages
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign q = r_stage[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/fifo_wptr_full.sv
//------------------------------------------------------------------------------
// Module  : fifo_wptr_full
// Brief   : Write-domain pointer and status manager of the dual-clock FIFO.
//           Define FIFO_SYNC3_EN for a 3-stage read-pointer synchronizer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fifo_wptr_full_if.slave bus
);
    localparam int c_a     = ADDR_WIDTH;
    localparam int c_ptr_w = ptr_width(ADDR_WIDTH);

    logic [c_ptr_w-1:0] r_wbin;
    logic [c_ptr_w-1:0] r_wgray;
    logic [c_ptr_w-1:0] r_level;
    logic               r_full;
    logic               r_almost_full;
    logic               r_overflow;

    logic               w_wr_fire;
    logic [c_ptr_w-1:0] w_wbin_next;
    logic [c_ptr_w-1:0] w_wgray_next;
    logic [c_ptr_w-1:0] w_rgray_sync;
    logic [c_ptr_w-1:0] w_rbin_sync;
    logic [c_ptr_w-1:0] w_rgray_full;
    logic [c_ptr_w-1:0] w_level_next;
    logic               w_full_next;
    logic               w_almost_full_next;

    assign w_wr_fire   = bus.wr_en & ~r_full;
    assign w_wbin_next = r_wbin + c_ptr_w'(w_wr_fire);

    bin_to_gray_gen #(.DATA_WIDTH(ADDR_WIDTH)) u_bin_to_gray (
        .bin  (w_wbin_next),
        .gray (w_wgray_next)
    );

    gray_ptr_sync #(.WIDTH(c_ptr_w), .STAGES(c_sync_stages)) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rptr_gray_async),
        .q     (w_rgray_sync)
    );

    gray_to_bin_gen #(.DATA_WIDTH(ADDR_WIDTH)) u_gray_to_bin (
        .gray (w_rgray_sync),
        .bin  (w_rbin_sync)
    );

    // Writer is a full lap ahead when the top two Gray bits differ, rest equal.
    assign w_rgray_full       = {~w_rgray_sync[c_a -: 2], w_rgray_sync[c_a-2:0]};
    assign w_full_next        = (w_wgray_next == w_rgray_full);
    assign w_level_next       = w_wbin_next - w_rbin_sync;
    assign w_almost_full_next = (32'(w_level_next) >= AF_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_level       <= w_level_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_overflow    <= bus.wr_en & r_full;
        end
    end

    assign bus.wr_fire     = w_wr_fire;
    assign bus.waddr       = r_wbin[c_a-1:0];
    assign bus.wptr_gray   = r_wgray;
    assign bus.full        = r_full;
    assign bus.almost_full = r_almost_full;
    assign bus.wr_level    = r_level;
    assign bus.overflow    = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
//------------------------------------------------------------------------------
// Module  : tb_fifo_wptr_full
// Brief   : Self-checking bench for fifo_wptr_full against an occupancy model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wptr_full;
    localparam int DEPTH = 16;
    localparam int MODV  = 32;
    localparam int AFT   = 12;
`ifdef FIFO_SYNC3_EN
    localparam int STG = 3;
`else
    localparam int STG = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    // Model: write count, read pointer driven, delayed view of read pointer.
    int m_w, m_rin, m_level;
    bit m_full, m_af, m_ovf;
    int hist[$];

    fifo_wptr_full_if #(.ADDR_WIDTH(4)) bus ();
    fifo_wptr_full #(.ADDR_WIDTH(4), .AF_THRESH(AFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_w = 0; m_rin = 0; m_level = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
        hist.delete();
        for (int i = 0; i < STG; i++) hist.push_back(0);
    endtask

    task automatic drive(input bit we);
        bus.wr_en = we;
        bus.rptr_gray_async = gray5(m_rin);
        #0;
    endtask

    task automatic tick();
        bit fire;
        int rs;
        @(posedge clk);
        fire    = bus.wr_en && !m_full;
        m_ovf   = bus.wr_en && m_full;
        m_w     = (m_w + int'(fire)) % MODV;
        rs      = hist.pop_front();
        hist.push_back(m_rin);
        m_level = (m_w - rs + MODV) % MODV;
        m_full  = (m_level == DEPTH);
        m_af    = (m_level >= AFT);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        drive(0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin drive(1); tick(); end
        n_total++;
        if (bus.wptr_gray !== gray5(3)) $display("FAIL pre_reset_gray: got %b want %b", bus.wptr_gray, gray5(3));
        else n_pass++;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        n_total++;
        if ({bus.wptr_gray, bus.wr_level, bus.waddr, bus.full, bus.almost_full, bus.overflow, bus.wr_fire} !== '0)
            $display("FAIL async_reset: gray=%b lvl=%0d waddr=%0d full=%b af=%b ovf=%b fire=%b", bus.wptr_gray,
                     bus.wr_level, bus.waddr, bus.full, bus.almost_full, bus.overflow, bus.wr_fire);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(0);
            tick();
            n_total++;
            if ({bus.wptr_gray, bus.wr_level, bus.waddr, bus.full, bus.almost_full, bus.overflow} !== '0)
                $display("FAIL idle_after_reset cycle %0d: gray=%b lvl=%0d full=%b af=%b ovf=%b", k,
                         bus.wptr_gray, bus.wr_level, bus.full, bus.almost_full, bus.overflow);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1);
            n_total++;
            if (bus.waddr !== 4'(i) || bus.wr_fire !== 1'b1)
                $display("FAIL fill_addr %0d: waddr=%0d fire=%b want waddr=%0d fire=1", i, bus.waddr, bus.wr_fire, i);
            else n_pass++;
            tick();
            if (i == AFT - 2 || i == AFT - 1) begin
                n_total++;
                if (bus.almost_full !== (i == AFT - 1))
                    $display("FAIL fill_af after write %0d: got %b want %b", i + 1, bus.almost_full, i == AFT - 1);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.full !== 1'b1 || bus.wptr_gray !== 5'b11000 || bus.wr_level !== 5'd16 || bus.almost_full !== 1'b1)
            $display("FAIL fill_end: full=%b gray=%b lvl=%0d af=%b want 1 11000 16 1", bus.full, bus.wptr_gray,
                     bus.wr_level, bus.almost_full);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            drive(1);
            n_total++;
            if (bus.wr_fire !== 1'b0) $display("FAIL ovf_fire %0d: got %b want 0", k, bus.wr_fire);
            else n_pass++;
            tick();
            n_total++;
            if (bus.overflow !== 1'b1 || bus.wptr_gray !== 5'b11000 || bus.wr_level !== 5'd16)
                $display("FAIL ovf_pulse %0d: ovf=%b gray=%b lvl=%0d want 1 11000 16", k, bus.overflow,
                         bus.wptr_gray, bus.wr_level);
            else n_pass++;
        end
        drive(0);
        tick();
        n_total++;
        if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.overflow);
        else n_pass++;
    endtask

    task automatic test_release();
        m_rin = 1;
        drive(0);
        for (int k = 1; k <= STG + 1; k++) begin
            tick();
            n_total++;
            if (k <= STG) begin
                if (bus.full !== 1'b1) $display("FAIL release_early edge %0d: full=%b want 1", k, bus.full);
                else n_pass++;
            end else begin
                if (bus.full !== 1'b0 || bus.wr_level !== 5'd15 || bus.almost_full !== 1'b1)
                    $display("FAIL release edge %0d: full=%b lvl=%0d af=%b want 0 15 1", k, bus.full,
                             bus.wr_level, bus.almost_full);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        bit wrapped = 0;
        do_reset();
        prev = bus.wptr_gray;
        for (int k = 0; k < 40; k++) begin
            m_rin = (m_w >= 4 || m_rin != 0) ? (m_w - 4 + MODV) % MODV : 0;
            drive(1);
            tick();
            if (prev == 5'b10000 && bus.wptr_gray == 5'b00000) wrapped = 1;
            prev = bus.wptr_gray;
            n_total++;
            if (bus.full !== 1'b0 || bus.wr_level !== 5'(m_level) || bus.wptr_gray !== gray5(m_w))
                $display("FAIL wrap %0d: full=%b lvl=%0d gray=%b want 0 %0d %b", k, bus.full, bus.wr_level,
                         bus.wptr_gray, m_level, gray5(m_w));
            else n_pass++;
            if (k >= 10) begin
                n_total++;
                if (bus.wr_level < 5'd4 || 32'(bus.wr_level) > 5 + STG)
                    $display("FAIL wrap_level %0d: got %0d want 4..%0d", k, bus.wr_level, 5 + STG);
                else n_pass++;
            end
        end
        n_total++;
        if (!wrapped) $display("FAIL wrap_seen: got 0 want 1");
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (AFT - 1) begin drive(1); tick(); end
        repeat (4) begin drive(0); tick(); end
        n_total++;
        if (bus.wr_level !== 5'(AFT - 1) || bus.almost_full !== 1'b0)
            $display("FAIL simul_pre: lvl=%0d af=%b want %0d 0", bus.wr_level, bus.almost_full, AFT - 1);
        else n_pass++;
        m_rin = 1;
        for (int k = 0; k < STG; k++) begin
            drive(0);
            tick();
            n_total++;
            if (bus.wr_level !== 5'(AFT - 1)) $display("FAIL simul_wait %0d: lvl=%0d want %0d", k, bus.wr_level, AFT - 1);
            else n_pass++;
        end
        drive(1);
        tick();
        n_total++;
        if (bus.wr_level !== 5'(AFT - 1) || bus.almost_full !== 1'b0 || bus.wptr_gray !== gray5(AFT))
            $display("FAIL simul_net: lvl=%0d af=%b gray=%b want %0d 0 %b", bus.wr_level, bus.almost_full,
                     bus.wptr_gray, AFT - 1, gray5(AFT));
        else n_pass++;
    endtask

    task automatic test_random();
        bit we;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            int rd_pct = (k < 200) ? 25 : 75;
            int wr_pct = (k < 200) ? 85 : 40;
            if (((m_w - m_rin + MODV) % MODV) > 0 && $urandom_range(99) < rd_pct)
                m_rin = (m_rin + 1) % MODV;
            we = ($urandom_range(99) < wr_pct);
            drive(we);
            n_total++;
            if (bus.wr_fire !== (we && !m_full) || bus.waddr !== 4'(m_w % DEPTH))
                $display("FAIL rand_comb %0d: fire=%b waddr=%0d want %b %0d", k, bus.wr_fire, bus.waddr,
                         we && !m_full, m_w % DEPTH);
            else n_pass++;
            tick();
            n_total++;
            if ({bus.wptr_gray, bus.wr_level, bus.full, bus.almost_full, bus.overflow} !==
                {gray5(m_w), 5'(m_level), m_full, m_af, m_ovf})
                $display("FAIL rand_state %0d: gray=%b lvl=%0d full=%b af=%b ovf=%b want %b %0d %b %b %b", k,
                         bus.wptr_gray, bus.wr_level, bus.full, bus.almost_full, bus.overflow,
                         gray5(m_w), m_level, m_full, m_af, m_ovf);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
